// File: rtl/aftab_trap_return_unit.sv
// aftab_trap_return_unit: MRET/URET sequencer restoring xstatus over the CSR port and returning resume PC/privilege.
// Define AFTAB_EPC_ALIGN_EN to force pcOut[1:0] to zero.
module aftab_trap_return_unit #(
  parameter int          len       = 32,
  parameter logic [11:0] MSTATUS_A = 12'h300,
  parameter logic [11:0] MEPC_A    = 12'h341,
  parameter logic [11:0] USTATUS_A = 12'h000,
  parameter logic [11:0] UEPC_A    = 12'h041
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_ret_start,
  input  logic           i_is_uret,
  input  logic [1:0]     i_cur_prv,
  output logic [11:0]    o_csr_addr,
  output logic           o_csr_rd,
  output logic           o_csr_wr,
  output logic [len-1:0] o_csr_wdata,
  input  logic [len-1:0] i_csr_rdata,
  input  logic           i_csr_ack,
  output logic           o_busy,
  output logic           o_ret_done,
  output logic           o_ret_illegal,
  output logic [len-1:0] o_pc_out,
  output logic [1:0]     o_new_prv
);
  typedef enum logic [2:0] {IDLE, RD_ST, WR_ST, RD_EPC, DONE, ILL} state_t;
  state_t         r_state;
  logic           r_is_u;
  logic [len-1:0] r_status;
  logic [len-1:0] w_wdata;
  logic [len-1:0] w_epc;
  always_comb begin
    w_wdata = r_status;
    if (r_is_u) begin
      w_wdata[0] = r_status[4];
      w_wdata[4] = 1'b1;
    end else begin
      w_wdata[3]     = r_status[7];
      w_wdata[7]     = 1'b1;
      w_wdata[12:11] = 2'b00;
    end
  end
`ifdef AFTAB_EPC_ALIGN_EN
  assign w_epc = {i_csr_rdata[len-1:2], 2'b00};
`else
  assign w_epc = i_csr_rdata;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_is_u        <= 1'b0;
      r_status      <= '0;
      o_csr_addr    <= '0;
      o_csr_rd      <= 1'b0;
      o_csr_wr      <= 1'b0;
      o_csr_wdata   <= '0;
      o_busy        <= 1'b0;
      o_ret_done    <= 1'b0;
      o_ret_illegal <= 1'b0;
      o_pc_out      <= '0;
      o_new_prv     <= 2'b11;
    end else begin
      o_ret_done    <= 1'b0;
      o_ret_illegal <= 1'b0;
      case (r_state)
        IDLE: if (i_ret_start) begin
          o_busy <= 1'b1;
          if (!i_is_uret && i_cur_prv != 2'b11) begin
            r_state       <= ILL;
            o_ret_illegal <= 1'b1;
          end else begin
            r_state    <= RD_ST;
            r_is_u     <= i_is_uret;
            o_csr_rd   <= 1'b1;
            o_csr_addr <= i_is_uret ? USTATUS_A : MSTATUS_A;
          end
        end
        RD_ST: if (o_csr_rd && i_csr_ack) begin
          r_status <= i_csr_rdata;
          o_csr_rd <= 1'b0;
          r_state  <= WR_ST;
        end
        WR_ST: if (!o_csr_wr) begin
          o_csr_wr    <= 1'b1;
          o_csr_wdata <= w_wdata;
        end else if (i_csr_ack) begin
          o_csr_wr <= 1'b0;
          r_state  <= RD_EPC;
        end
        RD_EPC: if (!o_csr_rd) begin
          o_csr_rd   <= 1'b1;
          o_csr_addr <= r_is_u ? UEPC_A : MEPC_A;
        end else if (i_csr_ack) begin
          o_csr_rd   <= 1'b0;
          o_pc_out   <= w_epc;
          o_new_prv  <= r_is_u ? 2'b00 : r_status[12:11];
          o_ret_done <= 1'b1;
          r_state    <= DONE;
        end
        DONE, ILL: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aftab_trap_return_unit.sv
// tb_aftab_trap_return_unit: directed checks of the MRET/URET sequencer against a waitable CSR responder.
module tb_aftab_trap_return_unit;
`ifdef AFTAB_EPC_ALIGN_EN
  localparam logic [31:0] EPC107 = 32'h104;
`else
  localparam logic [31:0] EPC107 = 32'h107;
`endif
  logic clk = 0, rst_n = 0, ret_start = 0, is_uret = 0, csr_ack = 0;
  logic [1:0] cur_prv = 2'b11;
  logic [11:0] csr_addr;
  logic csr_rd, csr_wr, busy, ret_done, ret_illegal;
  logic [31:0] csr_wdata, csr_rdata, pc_out;
  logic [1:0] new_prv;
  logic [31:0] mstatus_v = 0, ustatus_v = 0, mepc_v = 0, uepc_v = 0, wlog = 0;
  int wait_cfg = 0, cnt = 0, req_cycles = 0, unstable = 0, done_cnt = 0, total = 0, bad = 0;
  logic hold = 0, p_rd = 0, p_wr = 0;
  logic [11:0] p_addr = 0;
  logic [31:0] p_wdata = 0;
  always #5 clk = ~clk;
  aftab_trap_return_unit dut (
    .clk(clk), .rst_n(rst_n), .i_ret_start(ret_start), .i_is_uret(is_uret), .i_cur_prv(cur_prv),
    .o_csr_addr(csr_addr), .o_csr_rd(csr_rd), .o_csr_wr(csr_wr), .o_csr_wdata(csr_wdata),
    .i_csr_rdata(csr_rdata), .i_csr_ack(csr_ack), .o_busy(busy), .o_ret_done(ret_done),
    .o_ret_illegal(ret_illegal), .o_pc_out(pc_out), .o_new_prv(new_prv)
  );
  assign csr_rdata = csr_addr == 12'h300 ? mstatus_v : csr_addr == 12'h000 ? ustatus_v :
                     csr_addr == 12'h341 ? mepc_v : csr_addr == 12'h041 ? uepc_v : 32'hdead_beef;
  // CSR responder: acks after wait_cfg idle cycles of a held request
  always @(negedge clk) begin
    if (csr_rd || csr_wr) begin
      if (cnt >= wait_cfg) begin csr_ack = 1; cnt = 0; end
      else begin csr_ack = 0; cnt++; end
    end else begin csr_ack = 0; cnt = 0; end
  end
  always @(posedge clk) begin
    if (hold && (csr_rd !== p_rd || csr_wr !== p_wr || csr_addr !== p_addr || (csr_wr && csr_wdata !== p_wdata))) unstable++;
    if (csr_rd && csr_wr) unstable++;
    if (csr_rd || csr_wr) req_cycles++;
    if (csr_wr && csr_ack) wlog = csr_wdata;
    if (ret_done) done_cnt++;
    hold = (csr_rd || csr_wr) && !csr_ack;
    p_rd = csr_rd; p_wr = csr_wr; p_addr = csr_addr; p_wdata = csr_wdata;
  end
  task automatic run_ret(input logic u, input logic [1:0] prv, output int n);
    @(posedge clk); #1;
    req_cycles = 0; unstable = 0; done_cnt = 0; wlog = 'x;
    is_uret = u; cur_prv = prv; ret_start = 1;
    @(posedge clk); #1;
    ret_start = 0; n = 1;
    while (!ret_done && n < 60) begin @(posedge clk); #1; n++; end
  endtask
  task automatic test_reset;
    #12;
    total++; if (csr_addr !== 12'h0) begin bad++; $display("FAIL rst_addr got=%h exp=000", csr_addr); end
    total++; if (csr_rd !== 0 || csr_wr !== 0) begin bad++; $display("FAIL rst_req got=%b%b exp=00", csr_rd, csr_wr); end
    total++; if (csr_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", csr_wdata); end
    total++; if (busy !== 0 || ret_done !== 0 || ret_illegal !== 0) begin bad++; $display("FAIL rst_flags got=%b%b%b exp=000", busy, ret_done, ret_illegal); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
    total++; if (new_prv !== 2'b11) begin bad++; $display("FAIL rst_prv got=%b exp=11", new_prv); end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_mret;
    int n;
    mstatus_v = 32'h0000_1880; mepc_v = 32'h0000_0104; wait_cfg = 0;
    run_ret(0, 2'b11, n);
    total++; if (n !== 6) begin bad++; $display("FAIL mret_latency got=%0d exp=6", n); end
    total++; if (wlog !== 32'h88) begin bad++; $display("FAIL mret_wdata got=%h exp=00000088", wlog); end
    total++; if (pc_out !== 32'h104) begin bad++; $display("FAIL mret_pc got=%h exp=00000104", pc_out); end
    total++; if (new_prv !== 2'b11) begin bad++; $display("FAIL mret_prv got=%b exp=11", new_prv); end
    total++; if (busy !== 1) begin bad++; $display("FAIL mret_busy_done got=%b exp=1", busy); end
    @(posedge clk); #1;
    total++; if (ret_done !== 0 || busy !== 0) begin bad++; $display("FAIL mret_after got=%b%b exp=00", ret_done, busy); end
    total++; if (req_cycles !== 3 || unstable !== 0) begin bad++; $display("FAIL mret_bus got=%0d/%0d exp=3/0", req_cycles, unstable); end
  endtask
  task automatic test_uret_wait;
    int n;
    ustatus_v = 32'h0000_0010; uepc_v = 32'h0000_0200; mstatus_v = 32'h0000_1880; wait_cfg = 2;
    run_ret(1, 2'b00, n);
    total++; if (n !== 12) begin bad++; $display("FAIL uret_latency got=%0d exp=12", n); end
    total++; if (wlog !== 32'h11) begin bad++; $display("FAIL uret_wdata got=%h exp=00000011", wlog); end
    total++; if (pc_out !== 32'h200) begin bad++; $display("FAIL uret_pc got=%h exp=00000200", pc_out); end
    total++; if (new_prv !== 2'b00) begin bad++; $display("FAIL uret_prv got=%b exp=00", new_prv); end
    total++; if (req_cycles !== 9 || unstable !== 0) begin bad++; $display("FAIL uret_bus got=%0d/%0d exp=9/0", req_cycles, unstable); end
  endtask
  task automatic test_illegal;
    @(posedge clk); #1;
    req_cycles = 0; is_uret = 0; cur_prv = 2'b00; ret_start = 1;
    @(posedge clk); #1; ret_start = 0;
    total++; if (ret_illegal !== 1 || busy !== 1 || ret_done !== 0) begin bad++; $display("FAIL ill_pulse got=%b%b%b exp=110", ret_illegal, busy, ret_done); end
    @(posedge clk); #1;
    total++; if (ret_illegal !== 0 || busy !== 0) begin bad++; $display("FAIL ill_end got=%b%b exp=00", ret_illegal, busy); end
    repeat (4) @(posedge clk); #1;
    total++; if (req_cycles !== 0) begin bad++; $display("FAIL ill_noreq got=%0d exp=0", req_cycles); end
    total++; if (pc_out !== 32'h200 || new_prv !== 2'b00) begin bad++; $display("FAIL ill_hold got=%h/%b exp=00000200/00", pc_out, new_prv); end
  endtask
  task automatic test_back_to_back;
    mstatus_v = 32'h0000_0008; mepc_v = 32'h0000_0300; wait_cfg = 0;
    @(posedge clk); #1;
    req_cycles = 0; unstable = 0; done_cnt = 0; wlog = 'x;
    is_uret = 0; cur_prv = 2'b11; ret_start = 1;
    for (int c = 1; c <= 14; c++) begin @(posedge clk); #1; ret_start = (c >= 4 && c <= 6); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_done got=%0d exp=1", done_cnt); end
    total++; if (req_cycles !== 3) begin bad++; $display("FAIL b2b_reqs got=%0d exp=3", req_cycles); end
    total++; if (wlog !== 32'h80 || new_prv !== 2'b00) begin bad++; $display("FAIL b2b_restore got=%h/%b exp=00000080/00", wlog, new_prv); end
    total++; if (pc_out !== 32'h300 || busy !== 0) begin bad++; $display("FAIL b2b_pc got=%h/%b exp=00000300/0", pc_out, busy); end
  endtask
  task automatic test_align;
    int n;
    mstatus_v = 32'h0000_1880; mepc_v = 32'h0000_0107; wait_cfg = 1;
    run_ret(0, 2'b11, n);
    total++; if (n !== 9) begin bad++; $display("FAIL align_latency got=%0d exp=9", n); end
    total++; if (pc_out !== EPC107) begin bad++; $display("FAIL align_pc got=%h exp=%h", pc_out, EPC107); end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    mstatus_v = 32'h0000_1880; mepc_v = 32'h0000_0104; wait_cfg = 2;
    @(posedge clk); #1;
    is_uret = 0; cur_prv = 2'b11; ret_start = 1;
    @(posedge clk); #1; ret_start = 0;
    while (!csr_wr && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (csr_wr !== 1) begin bad++; $display("FAIL mid_reach_wr got=%b exp=1", csr_wr); end
    rst_n = 0; #1;
    total++; if (csr_rd !== 0 || csr_wr !== 0 || csr_addr !== 12'h0 || csr_wdata !== 32'h0) begin bad++; $display("FAIL mid_bus got=%b%b/%h/%h exp=00/000/0", csr_rd, csr_wr, csr_addr, csr_wdata); end
    total++; if (busy !== 0 || pc_out !== 32'h0 || new_prv !== 2'b11) begin bad++; $display("FAIL mid_state got=%b/%h/%b exp=0/0/11", busy, pc_out, new_prv); end
    @(negedge clk); rst_n = 1;
    repeat (3) @(posedge clk); #1;
    total++; if (busy !== 0 || csr_rd !== 0 || csr_wr !== 0) begin bad++; $display("FAIL mid_idle got=%b%b%b exp=000", busy, csr_rd, csr_wr); end
  endtask
  initial begin
    test_reset;
    test_mret;
    test_uret_wait;
    test_illegal;
    test_back_to_back;
    test_align;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
